// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory port arbiter.
// FSM state and requester-owner encodings plus width defaults.
package imem_arb_pkg;

  localparam int AWIDTH_DEF = 32;
  localparam int DWIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_RESP
  } state_t;

  typedef enum logic {
    OWN_F,
    OWN_D
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant (fetch vs data).
// A tie goes to whoever was not granted last; history moves only on accept.
module rr_arb2
  import imem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_f_i,
  input  logic   req_d_i,
  input  logic   adv_i,
  output logic   gnt_f_o,
  output logic   gnt_d_o,
  output owner_t gnt_own_o
);

  owner_t last_q;

  // Fetch wins when alone or when data was the last grantee.
  always_comb begin
    gnt_f_o   = req_f_i & (~req_d_i | (last_q == OWN_D));
    gnt_d_o   = req_d_i & ~gnt_f_o;
    gnt_own_o = gnt_d_o ? OWN_D : OWN_F;
  end

  // Remember the grantee of each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_D;
    end else if (adv_i) begin
      last_q <= gnt_own_o;
    end
  end

endmodule

// File: rtl/imem_port_arb.sv
// Shares one combinational instruction memory between fetch and data reads.
// Define IMEM_MISALIGN_CHK_EN to flag unaligned addresses with rsp_err.
module imem_port_arb
  import imem_arb_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [AWIDTH-1:0] f_addr,
  output logic              f_rsp_valid,
  output logic [DWIDTH-1:0] f_rsp_data,
  output logic              f_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [AWIDTH-1:0] d_addr,
  output logic              d_rsp_valid,
  output logic [DWIDTH-1:0] d_rsp_data,
  output logic              d_rsp_err,
  input  logic              flush,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_rdata
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              kill_q, kill_d;
  logic              open, acc;
  logic              gnt_f, gnt_d;
  owner_t            gnt_own;

`ifdef IMEM_MISALIGN_CHK_EN
  logic              err_q, err_d;
`endif

  assign open = (state_q == ST_IDLE) | (state_q == ST_RESP);
  assign acc  = open & (gnt_f | gnt_d);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_f_i   (f_req_valid & ~flush),
    .req_d_i   (d_req_valid),
    .adv_i     (acc),
    .gnt_f_o   (gnt_f),
    .gnt_d_o   (gnt_d),
    .gnt_own_o (gnt_own)
  );

  // Next-state: accept in IDLE/RESP, read memory in READ.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    data_d  = data_q;
    kill_d  = kill_q;
`ifdef IMEM_MISALIGN_CHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (acc) begin
          state_d = ST_READ;
          owner_d = gnt_own;
          addr_d  = (gnt_own == OWN_D) ? d_addr : f_addr;
          kill_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d = ST_RESP;
        data_d  = mem_rdata;
`ifdef IMEM_MISALIGN_CHK_EN
        err_d   = 1'b0;
        if (addr_q[1:0] != 2'b00) begin
          data_d = '0;
          err_d  = 1'b1;
        end
`endif
        if (flush && owner_q == OWN_F) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction registers; reset abandons any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_F;
      addr_q  <= '0;
      data_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      kill_q  <= kill_d;
    end
  end

`ifdef IMEM_MISALIGN_CHK_EN
  // Misalignment flag travels with the captured word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  assign f_req_ready = open & gnt_f;
  assign d_req_ready = open & gnt_d;
  assign mem_addr    = addr_q;
  assign f_rsp_data  = data_q;
  assign d_rsp_data  = data_q;

  assign f_rsp_valid = (state_q == ST_RESP) & (owner_q == OWN_F)
                     & ~kill_q & ~flush;
  assign d_rsp_valid = (state_q == ST_RESP) & (owner_q == OWN_D);

`ifdef IMEM_MISALIGN_CHK_EN
  assign f_rsp_err = f_rsp_valid & err_q;
  assign d_rsp_err = d_rsp_valid & err_q;
`else
  assign f_rsp_err = 1'b0;
  assign d_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_port_arb.sv
// Bench for imem_port_arb: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_imem_port_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req_valid, f_req_ready;
  logic [31:0] f_addr;
  logic        f_rsp_valid;
  logic [31:0] f_rsp_data;
  logic        f_rsp_err;
  logic        d_req_valid, d_req_ready;
  logic [31:0] d_addr;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  logic        flush;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  logic [7:0]  mem [256];

  int n_chk = 0;
  int n_fail = 0;

  imem_port_arb #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_req_valid (f_req_valid),
    .f_req_ready (f_req_ready),
    .f_addr      (f_addr),
    .f_rsp_valid (f_rsp_valid),
    .f_rsp_data  (f_rsp_data),
    .f_rsp_err   (f_rsp_err),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_addr      (d_addr),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_data  (d_rsp_data),
    .d_rsp_err   (d_rsp_err),
    .flush       (flush),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
  endfunction

  always_comb mem_rdata = rd_word(mem_addr);

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic exp_rsp(input logic [31:0] a, output logic [31:0] d,
                         output logic e);
`ifdef IMEM_MISALIGN_CHK_EN
    e = (a[1:0] != 2'b00);
    d = e ? 32'h0 : rd_word(a);
`else
    e = 1'b0;
    d = rd_word(a);
`endif
  endtask

  // Model: one transaction at a time, response two cycles after accept.
  int          cyc = 0;
  bit          have = 0;
  int          tcyc = 0;
  bit          town_d = 0;
  logic [31:0] taddr = 0;
  bit          killed = 0;
  bit          lastd = 1;

  always @(negedge clk) begin : cmp
    bit free, ef, ed, fv, dv, gf, gd;
    logic [31:0] xd;
    logic xe;
    cyc++;
    if (!rst_n) begin
      have  = 0;
      lastd = 1;
      chk("rst_f_rsp_valid", f_rsp_valid, 0);
      chk("rst_d_rsp_valid", d_rsp_valid, 0);
      chk("rst_rsp_err", {f_rsp_err, d_rsp_err}, 0);
      chk("rst_mem_addr", mem_addr, 0);
    end else begin
      free = !have || (cyc == tcyc + 2);
      ef = 0;
      ed = 0;
      xd = 0;
      xe = 0;
      if (have && cyc == tcyc + 1) begin
        chk("mem_addr", mem_addr, taddr);
        if (!town_d && flush) killed = 1;
      end
      if (have && cyc == tcyc + 2) begin
        exp_rsp(taddr, xd, xe);
        if (town_d) ed = 1;
        else ef = !killed && !flush;
        if (ef) chk("f_rsp_data", f_rsp_data, xd);
        if (ed) chk("d_rsp_data", d_rsp_data, xd);
      end
      chk("f_rsp_valid", f_rsp_valid, ef);
      chk("d_rsp_valid", d_rsp_valid, ed);
      chk("f_rsp_err", f_rsp_err, ef ? xe : 1'b0);
      chk("d_rsp_err", d_rsp_err, ed ? xe : 1'b0);
      fv = f_req_valid && !flush;
      dv = d_req_valid;
      gf = 0;
      gd = 0;
      if (free) begin
        if (fv && (!dv || lastd)) gf = 1;
        else if (dv) gd = 1;
      end
      chk("f_req_ready", f_req_ready, gf);
      chk("d_req_ready", d_req_ready, gd);
      if (gf || gd) begin
        have   = 1;
        tcyc   = cyc;
        town_d = gd;
        taddr  = gd ? d_addr : f_addr;
        killed = 0;
        lastd  = gd;
      end else if (have && cyc == tcyc + 2) begin
        have = 0;
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_word(int a, logic [31:0] w);
    mem[a]     = w[7:0];
    mem[a + 1] = w[15:8];
    mem[a + 2] = w[23:16];
    mem[a + 3] = w[31:24];
  endtask

  // Present a lone fetch in IDLE; returns just after the accepting edge.
  task automatic issue_f(logic [31:0] a);
    f_req_valid = 1'b1;
    f_addr      = a;
    @(negedge clk);
    chk("issue_f_ready", f_req_ready, 1);
    @(posedge clk);
    #1;
    f_req_valid = 1'b0;
  endtask

  task automatic wait_f(output int lat, output logic [31:0] d,
                        output logic e, output logic oth);
    lat = -1;
    d   = 0;
    e   = 0;
    oth = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (f_rsp_valid) begin
        lat = i;
        d   = f_rsp_data;
        e   = f_rsp_err;
        oth = d_rsp_valid;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : drive
    int lat, fc, dc, ng;
    logic [31:0] d;
    logic e, oth, acc;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    put_word(32'h0C, 32'h404404B3);
    put_word(32'h10, 32'h00C58533);
    put_word(32'h14, 32'h0FF00093);
    rst_n       = 1'b0;
    f_req_valid = 1'b0;
    d_req_valid = 1'b0;
    f_addr      = 0;
    d_addr      = 0;
    flush       = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_rsp_valid", {f_rsp_valid, d_rsp_valid}, 0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Lone fetch at 0x0C.
    issue_f(32'h0C);
    wait_f(lat, d, e, oth);
    chk("t1_latency", lat, 2);
    chk("t1_data", d, 32'h404404B3);
    chk("t1_d_rsp_valid", oth, 0);
    step(3);

    // Both requesting from reset: grants alternate F,D,F,D...
    do_reset();
    f_req_valid = 1'b1;
    f_addr      = 32'h10;
    d_req_valid = 1'b1;
    d_addr      = 32'h14;
    ng = 0;
    for (int i = 0; i < 30 && ng < 8; i++) begin
      @(negedge clk);
      if (f_req_ready || d_req_ready) begin
        chk("t2_rr_grant", {f_req_ready, d_req_ready},
            (ng % 2 == 0) ? 2'b10 : 2'b01);
        ng++;
      end
      @(posedge clk);
      #1;
    end
    f_req_valid = 1'b0;
    d_req_valid = 1'b0;
    chk("t2_grant_count", ng, 8);
    step(4);

    // Flush during READ kills the fetch; data request still served.
    issue_f(32'h0C);
    flush       = 1'b1;
    d_req_valid = 1'b1;
    d_addr      = 32'h14;
    fc = 0;
    dc = 0;
    d  = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (f_rsp_valid) fc++;
      if (d_rsp_valid) begin
        dc++;
        d = d_rsp_data;
      end
      acc = d_req_valid && d_req_ready;
      @(posedge clk);
      #1;
      flush = 1'b0;
      if (acc) d_req_valid = 1'b0;
    end
    chk("t3_f_rsp_count", fc, 0);
    chk("t3_d_rsp_count", dc, 1);
    chk("t3_d_data", d, 32'h0FF00093);
    step(2);

    // Unaligned fetch at 0x0E.
    issue_f(32'h0E);
    wait_f(lat, d, e, oth);
    chk("t4_latency", lat, 2);
`ifdef IMEM_MISALIGN_CHK_EN
    chk("t4_err", e, 1);
    chk("t4_data", d, 32'h0);
`else
    chk("t4_err", e, 0);
    chk("t4_data", d, 32'h85334044);
`endif
    step(3);

    // Reset during READ abandons the fetch.
    issue_f(32'h10);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    fc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (f_rsp_valid) fc++;
    end
    chk("t5_no_rsp", fc, 0);
    step(1);
    issue_f(32'h14);
    wait_f(lat, d, e, oth);
    chk("t5_latency", lat, 2);
    chk("t5_data", d, 32'h0FF00093);
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
